// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC predictor: EX branch-kind encodings and boot address.
package npc_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JIRL = 2'b10;
  localparam logic [1:0] BR_B    = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

endpackage

// File: rtl/btb_bank.sv
// Direct-mapped BTB storage: {valid, tag, target, ctr} per entry, async read ports,
// one synchronous write port. Reads return pre-write contents in the write cycle.
module btb_bank #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 26,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              lk_valid,
  output logic [TAG_W-1:0]  lk_tag,
  output logic [ADDR_W-1:0] lk_target,
  output logic [CTR_W-1:0]  lk_ctr,
  input  logic [IDX_W-1:0]  rs_idx,
  output logic              rs_valid,
  output logic [TAG_W-1:0]  rs_tag,
  output logic [ADDR_W-1:0] rs_target,
  output logic [CTR_W-1:0]  rs_ctr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_target,
  input  logic [CTR_W-1:0]  wr_ctr
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1);

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [ADDR_W-1:0]  target_r [ENTRIES];
  logic [CTR_W-1:0]   ctr_r    [ENTRIES];

  // Entry storage: reset clears every entry to invalid / weakly not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        ctr_r[i]    <= CTR_INIT;
      end
    end else if (wr_en) begin
      valid_r[wr_idx]  <= 1'b1;
      tag_r[wr_idx]    <= wr_tag;
      target_r[wr_idx] <= wr_target;
      ctr_r[wr_idx]    <= wr_ctr;
    end
  end

  assign lk_valid  = valid_r[lk_idx];
  assign lk_tag    = tag_r[lk_idx];
  assign lk_target = target_r[lk_idx];
  assign lk_ctr    = ctr_r[lk_idx];

  assign rs_valid  = valid_r[rs_idx];
  assign rs_tag    = tag_r[rs_idx];
  assign rs_target = target_r[rs_idx];
  assign rs_ctr    = ctr_r[rs_idx];

endmodule

// File: rtl/npc_predict_unit.sv
// IF-stage next-PC generator: owns the PC, predicts from the BTB, resolves EX branches
// and redirects the fetch stream (flush) on a mispredict.
module npc_predict_unit
  import npc_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter int              CTR_W       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pred_npc,
  input  logic              ex_valid,
  input  logic [1:0]        ex_kind,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_base,
  input  logic [ADDR_W-1:0] ex_offset,
  input  logic [ADDR_W-1:0] ex_pred_npc,
  output logic              flush
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0]  CTR_MAX     = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_WEAK_NT = CTR_W'(1);
  localparam logic [ADDR_W-1:0] INSN_BYTES  = ADDR_W'(4);

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
    if (c == CTR_MAX) return c;
    else              return c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
    if (c == CTR_W'(0)) return c;
    else                return c - CTR_W'(1);
  endfunction

  logic [ADDR_W-1:0] pc_r;

  logic [IDX_W-1:0]  lk_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic              lk_valid_s;
  logic [TAG_W-1:0]  lk_tag_rd_s;
  logic [ADDR_W-1:0] lk_target_s;
  logic [CTR_W-1:0]  lk_ctr_s;
  logic              lk_hit_s;
  logic [ADDR_W-1:0] pred_npc_s;

  logic [IDX_W-1:0]  rs_idx_s;
  logic [TAG_W-1:0]  rs_tag_s;
  logic              rs_valid_s;
  logic [TAG_W-1:0]  rs_tag_rd_s;
  logic [ADDR_W-1:0] rs_target_s;
  logic [CTR_W-1:0]  rs_ctr_s;
  logic              rs_hit_s;

  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] actual_npc_s;
  logic              flush_s;

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_target_s;
  logic [CTR_W-1:0]  wr_ctr_s;

  assign lk_idx_s = pc_r[IDX_W+1:2];
  assign lk_tag_s = pc_r[ADDR_W-1:IDX_W+2];
  assign rs_idx_s = ex_pc[IDX_W+1:2];
  assign rs_tag_s = ex_pc[ADDR_W-1:IDX_W+2];

  btb_bank #(
    .ENTRIES (BTB_ENTRIES),
    .TAG_W   (TAG_W),
    .ADDR_W  (ADDR_W),
    .CTR_W   (CTR_W),
    .IDX_W   (IDX_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lk_idx    (lk_idx_s),
    .lk_valid  (lk_valid_s),
    .lk_tag    (lk_tag_rd_s),
    .lk_target (lk_target_s),
    .lk_ctr    (lk_ctr_s),
    .rs_idx    (rs_idx_s),
    .rs_valid  (rs_valid_s),
    .rs_tag    (rs_tag_rd_s),
    .rs_target (rs_target_s),
    .rs_ctr    (rs_ctr_s),
    .wr_en     (wr_en_s),
    .wr_idx    (rs_idx_s),
    .wr_tag    (rs_tag_s),
    .wr_target (wr_target_s),
    .wr_ctr    (wr_ctr_s)
  );

  assign lk_hit_s = lk_valid_s && (lk_tag_rd_s == lk_tag_s);
  assign rs_hit_s = rs_valid_s && (rs_tag_rd_s == rs_tag_s);

  // Fetch prediction: follow the BTB only when it hits and the counter leans taken.
  always_comb begin
    pred_npc_s = pc_r + INSN_BYTES;
    if (lk_hit_s && lk_ctr_s[CTR_W-1]) begin
      pred_npc_s = lk_target_s;
    end else begin
      pred_npc_s = pc_r + INSN_BYTES;
    end
  end

  // Resolve the EX instruction into the address that really follows it.
  always_comb begin
    target_s     = ex_pc + ex_offset;
    actual_npc_s = ex_pc + INSN_BYTES;
    case (ex_kind)
      BR_NONE: actual_npc_s = ex_pc + INSN_BYTES;
      BR_COND: begin
        if (ex_taken) actual_npc_s = target_s;
        else          actual_npc_s = ex_pc + INSN_BYTES;
      end
      BR_JIRL: begin
        target_s     = ex_base + ex_offset;
        actual_npc_s = target_s;
      end
      BR_B:    actual_npc_s = target_s;
      default: actual_npc_s = ex_pc + INSN_BYTES;
    endcase
  end

  assign flush_s = ex_valid && !rst && (actual_npc_s != ex_pred_npc);

  // BTB training from the resolved EX instruction; not-taken misses leave the table alone.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_target_s = target_s;
    wr_ctr_s    = CTR_MAX;
    if (ex_valid && !rst) begin
      case (ex_kind)
        BR_B, BR_JIRL: begin
          wr_en_s  = 1'b1;
          wr_ctr_s = CTR_MAX;
        end
        BR_COND: begin
          if (ex_taken) begin
            wr_en_s  = 1'b1;
            wr_ctr_s = sat_inc(rs_hit_s ? rs_ctr_s : CTR_WEAK_NT);
          end else if (rs_hit_s) begin
            wr_en_s     = 1'b1;
            wr_target_s = rs_target_s;
            wr_ctr_s    = sat_dec(rs_ctr_s);
          end else begin
            wr_en_s = 1'b0;
          end
        end
        default: wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // PC register: a redirect overrides stall, stall overrides the prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (flush_s) begin
      pc_r <= actual_npc_s;
    end else if (stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= pred_npc_s;
    end
  end

  assign pc       = pc_r;
  assign pred_npc = pred_npc_s;
  assign flush    = flush_s;

endmodule

// File: tb/tb_npc_predict_unit.sv
// Scoreboard bench for npc_predict_unit: a behavioural BTB/PC model predicts pc, pred_npc
// and flush for every driven cycle; the negedge checker compares them against the DUT.
module tb_npc_predict_unit;
  import npc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, ex_taken, flush;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc, ex_base, ex_offset, ex_pred_npc, pc, pred_npc;

  always #5 clk = ~clk;

  npc_predict_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .pred_npc(pred_npc),
    .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_taken(ex_taken), .ex_pc(ex_pc),
    .ex_base(ex_base), .ex_offset(ex_offset), .ex_pred_npc(ex_pred_npc), .flush(flush)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        flush;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: 16-entry direct-mapped table, counters kept as integers 0..3.
  bit          m_valid  [16];
  logic [25:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  logic [31:0] m_pc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pred(input logic [31:0] a);
    int i;
    i = int'(a[5:2]);
    if (m_valid[i] && m_tag[i] == a[31:6] && m_ctr[i] >= 2) return m_target[i];
    return a + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    for (int j = 0; j < 16; j++) begin
      m_valid[j] = 1'b0; m_tag[j] = 26'd0; m_target[j] = 32'd0; m_ctr[j] = 1;
    end
  endtask

  // Compare the DUT against the oldest outstanding expectation, away from the clock edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq("pc", pc, e.pc);
      check_eq("pred_npc", pred_npc, e.npc);
      check_eq("flush", {31'd0, flush}, {31'd0, e.flush});
    end
  end

  task automatic step(input logic r, input logic s, input logic v, input logic [1:0] k,
                      input logic t, input logic [31:0] epc, input logic [31:0] base,
                      input logic [31:0] off, input logic [31:0] epred);
    logic [31:0] tgt, act;
    logic        fl, hit;
    int          i;
    exp_t        e;
    rst = r; stall = s; ex_valid = v; ex_kind = k; ex_taken = t;
    ex_pc = epc; ex_base = base; ex_offset = off; ex_pred_npc = epred;
    tgt = (k == BR_JIRL) ? base + off : epc + off;
    act = (k == BR_NONE || (k == BR_COND && !t)) ? epc + 32'd4 : tgt;
    fl  = !r && v && (act != epred);
    e.pc = m_pc; e.npc = model_pred(m_pc); e.flush = fl;
    sb_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      if (fl) m_pc = act;
      else if (!s) m_pc = e.npc;
      if (v) begin
        i   = int'(epc[5:2]);
        hit = m_valid[i] && m_tag[i] == epc[31:6];
        if (k == BR_B || k == BR_JIRL) begin
          m_valid[i] = 1'b1; m_tag[i] = epc[31:6]; m_target[i] = tgt; m_ctr[i] = 3;
        end else if (k == BR_COND && t) begin
          m_ctr[i]   = hit ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : 2;
          m_valid[i] = 1'b1; m_tag[i] = epc[31:6]; m_target[i] = tgt;
        end else if (k == BR_COND && hit) begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic s);
    step(1'b0, s, 1'b0, BR_NONE, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Force the fetch stream to address a via a mispredicted plain instruction in EX.
  task automatic redir(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b1, BR_NONE, 1'b0, a - 32'd4, 32'd0, 32'd0, 32'hffff_fff0);
  endtask

  initial begin
    logic [31:0] r_pc, r_off, r_pred;
    logic [1:0]  r_kind;
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_kind = BR_NONE; ex_taken = 1'b0;
    ex_pc = 32'd0; ex_base = 32'd0; ex_offset = 32'd0; ex_pred_npc = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then free-running sequential fetch.
    repeat (3) step(1'b1, 1'b0, 1'b0, BR_NONE, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (4) idle(1'b0);

    // Unconditional B: first resolve mispredicts, second is predicted.
    step(1'b0, 1'b0, 1'b1, BR_B, 1'b0, 32'h1c00_0010, 32'd0, 32'h40, 32'h1c00_0014);
    step(1'b0, 1'b0, 1'b1, BR_B, 1'b0, 32'h1c00_0010, 32'd0, 32'h40, model_pred(32'h1c00_0010));
    redir(32'h1c00_0010);
    idle(1'b0);

    // Conditional branch: taken, taken, not-taken, not-taken.
    step(1'b0, 1'b0, 1'b1, BR_COND, 1'b1, 32'h1c00_0020, 32'd0, 32'h100, model_pred(32'h1c00_0020));
    step(1'b0, 1'b0, 1'b1, BR_COND, 1'b1, 32'h1c00_0020, 32'd0, 32'h100, model_pred(32'h1c00_0020));
    step(1'b0, 1'b0, 1'b1, BR_COND, 1'b0, 32'h1c00_0020, 32'd0, 32'h100, model_pred(32'h1c00_0020));
    step(1'b0, 1'b0, 1'b1, BR_COND, 1'b0, 32'h1c00_0020, 32'd0, 32'h100, model_pred(32'h1c00_0020));
    redir(32'h1c00_0020);
    idle(1'b0);

    // JIRL redirect while stalled.
    step(1'b0, 1'b1, 1'b1, BR_JIRL, 1'b0, 32'h1c00_0030, 32'h1c00_1000, 32'd8, 32'h1c00_0034);
    idle(1'b0);

    // Aliasing: 1c000050 evicts 1c000010 from the shared index.
    step(1'b0, 1'b0, 1'b1, BR_B, 1'b0, 32'h1c00_0050, 32'd0, 32'h20, model_pred(32'h1c00_0050));
    redir(32'h1c00_0010);
    idle(1'b1);

    // Update and lookup of the same index in one cycle.
    step(1'b0, 1'b1, 1'b1, BR_B, 1'b0, 32'h1c00_0010, 32'd0, 32'h80, 32'h1c00_0090);
    idle(1'b1);
    idle(1'b0);

    // Randomised traffic over a small address window to exercise aliasing and counters.
    for (int n = 0; n < 400; n++) begin
      r_pc   = 32'h1c00_0000 + (32'($urandom_range(0, 47)) << 2);
      r_off  = 32'($urandom_range(1, 24)) << 2;
      r_kind = 2'($urandom_range(0, 3));
      r_pred = ($urandom_range(0, 3) != 0) ? model_pred(r_pc) : r_pc + 32'd4;
      step(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
           r_kind, 1'($urandom_range(0, 1)), r_pc,
           32'h1c00_0400 + (32'($urandom_range(0, 15)) << 2), r_off, r_pred);
    end

    // Reset mid-operation with a mispredicting B in EX: no flush, table wiped.
    step(1'b0, 1'b0, 1'b1, BR_B, 1'b0, 32'h1c00_0010, 32'd0, 32'h40, model_pred(32'h1c00_0010));
    step(1'b1, 1'b0, 1'b1, BR_B, 1'b0, 32'h1c00_0010, 32'd0, 32'h40, 32'h1c00_0014);
    redir(32'h1c00_0010);
    idle(1'b0);

    @(negedge clk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
